// File: rtl/addw_skid_reg_pkg.sv
// Shared definitions for the addw output skid stage: state encodings and default width.
package addw_skid_reg_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  localparam int ADDW_WIDTH = 4;

  // The spare encoding 2'd3 is deliberately treated as empty.
  function automatic logic holds_entry(input skid_state_e s);
    return (s == SKID_ONE) || (s == SKID_FULL);
  endfunction

endpackage

// File: rtl/addw_skid_reg_skid_slot.sv
// One storage slot of the skid stage: {predicate, data} register with load enable and sync clear.
module skid_slot #(
  parameter int width = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [width:0]   d,
  output logic [width:0]   q
);

  logic [width:0] data_d;
  logic [width:0] data_q;

  always_comb begin
    data_d = data_q;
    if (clear) begin
      data_d = '0;
    end else if (load) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/addw_skid_reg.sv
// Registered two-entry skid output stage for the addw sum and its predicate.
module addw_skid_reg
  import addw_skid_reg_pkg::*;
#(
  parameter int width = ADDW_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] i0,
  input  logic             i0_enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [width-1:0] o0,
  output logic             o0_enable,
  output logic             out_valid,
  input  logic             out_ready
);

  skid_state_e    state_q;
  skid_state_e    state_d;
  logic           accept;
  logic           pop;
  logic           head_load;
  logic           head_from_skid;
  logic           skid_load;
  logic [width:0] in_entry;
  logic [width:0] head_in;
  logic [width:0] head_q;
  logic [width:0] skid_q;

  // Both handshake outputs come straight from the state register.
  assign in_ready  = (state_q != SKID_FULL);
  assign out_valid = holds_entry(state_q);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign in_entry  = {i0_enable, i0};
  assign head_in   = head_from_skid ? skid_q : in_entry;

  always_comb begin
    state_d        = state_q;
    head_load      = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    unique case (state_q)
      SKID_ONE: begin
        if (accept && !pop) begin
          state_d   = SKID_FULL;
          skid_load = 1'b1;
        end else if (pop && !accept) begin
          state_d = SKID_EMPTY;
        end else if (accept && pop) begin
          head_load = 1'b1;
        end
      end
      SKID_FULL: begin
        if (pop) begin
          state_d        = SKID_ONE;
          head_load      = 1'b1;
          head_from_skid = 1'b1;
        end
      end
      default: begin
        if (accept) begin
          state_d   = SKID_ONE;
          head_load = 1'b1;
        end
      end
    endcase
    // Flush wins over any concurrent accept or pop; the slots clear themselves.
    if (flush) begin
      state_d   = SKID_EMPTY;
      head_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SKID_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  skid_slot #(.width(width)) u_head (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .load  (head_load),
    .d     (head_in),
    .q     (head_q)
  );

  skid_slot #(.width(width)) u_skid (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .load  (skid_load),
    .d     (in_entry),
    .q     (skid_q)
  );

  assign o0        = head_q[width-1:0];
  assign o0_enable = head_q[width];

endmodule

// File: tb/tb_addw_skid_reg.sv
// Self-checking bench for addw_skid_reg: directed vector table followed by a queue-model random soak.
module tb_addw_skid_reg;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic [W-1:0] i0;
  logic         i0_enable;
  logic         in_valid;
  logic         in_ready;
  logic         flush;
  logic [W-1:0] o0;
  logic         o0_enable;
  logic         out_valid;
  logic         out_ready;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string        name;
    logic         rst;
    logic         fl;
    logic         iv;
    logic [W-1:0] data;
    logic         en;
    logic         ordy;
    logic         chkData;
    logic         expOv;
    logic         expIr;
    logic [W-1:0] expO0;
    logic         expEn;
  } vec_t;

  vec_t vecs[$];

  typedef logic [W:0] entry_t;
  entry_t model[$];

  addw_skid_reg #(.width(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .i0        (i0),
    .i0_enable (i0_enable),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .o0        (o0),
    .o0_enable (o0_enable),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Append one directed cycle: inputs, then outputs expected just after the edge
  task automatic addVec(input string name, input logic rst, input logic fl, input logic iv,
                        input logic [W-1:0] data, input logic en, input logic ordy,
                        input logic chkData, input logic expOv, input logic expIr,
                        input logic [W-1:0] expO0, input logic expEn);
    vec_t v;
    v.name = name; v.rst = rst; v.fl = fl; v.iv = iv; v.data = data; v.en = en;
    v.ordy = ordy; v.chkData = chkData; v.expOv = expOv; v.expIr = expIr;
    v.expO0 = expO0; v.expEn = expEn;
    vecs.push_back(v);
  endtask

  // Drive all DUT inputs with blocking assignments
  task automatic applyStimulus(input logic rst, input logic fl, input logic iv,
                               input logic [W-1:0] data, input logic en, input logic ordy);
    reset     = rst;
    flush     = fl;
    in_valid  = iv;
    i0        = data;
    i0_enable = en;
    out_ready = ordy;
  endtask

  // One comparison; prints a FAIL line on mismatch
  task automatic checkOutput(input string name, input int idx, input logic [7:0] act,
                             input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (step %0d): actual=%0d expected=%0d", name, idx, act, exp);
    end
  endtask

  // Directed table covering reset, streaming, back-pressure, accept+pop, flush and X safety
  task automatic buildTable();
    //      name              rst fl iv data en ordy chk ov ir o0 en
    addVec("reset",           1, 0, 0, 4'd0, 0, 0,   1, 0, 1, 4'd0, 0);
    addVec("stream_3",        0, 0, 1, 4'd3, 1, 1,   1, 1, 1, 4'd3, 1);
    addVec("stream_7",        0, 0, 1, 4'd7, 0, 1,   1, 1, 1, 4'd7, 0);
    addVec("stream_15",       0, 0, 1, 4'd15, 1, 1,  1, 1, 1, 4'd15, 1);
    addVec("stream_drain",    0, 0, 0, 4'd0, 0, 1,   0, 0, 1, 4'd0, 0);
    addVec("bp_push5",        0, 0, 1, 4'd5, 1, 0,   1, 1, 1, 4'd5, 1);
    addVec("bp_push9_full",   0, 0, 1, 4'd9, 0, 0,   1, 1, 0, 4'd5, 1);
    addVec("bp_stall_hold",   0, 0, 1, 4'd13, 1, 0,  1, 1, 0, 4'd5, 1);
    addVec("bp_pop5",         0, 0, 0, 4'd0, 0, 1,   1, 1, 1, 4'd9, 0);
    addVec("bp_pop9",         0, 0, 0, 4'd0, 0, 1,   0, 0, 1, 4'd0, 0);
    addVec("ap_head2",        0, 0, 1, 4'd2, 1, 0,   1, 1, 1, 4'd2, 1);
    addVec("ap_push6_pop2",   0, 0, 1, 4'd6, 1, 1,   1, 1, 1, 4'd6, 1);
    addVec("ap_pop6",         0, 0, 0, 4'd0, 0, 1,   0, 0, 1, 4'd0, 0);
    addVec("fl_push4",        0, 0, 1, 4'd4, 1, 0,   1, 1, 1, 4'd4, 1);
    addVec("fl_push8",        0, 0, 1, 4'd8, 0, 0,   1, 1, 0, 4'd4, 1);
    addVec("fl_flush12",      0, 1, 1, 4'd12, 1, 0,  0, 0, 1, 4'd0, 0);
    addVec("fl_after",        0, 0, 0, 4'd0, 0, 1,   0, 0, 1, 4'd0, 0);
    addVec("rst_push1",       0, 0, 1, 4'd1, 1, 0,   1, 1, 1, 4'd1, 1);
    addVec("rst_push14",      0, 0, 1, 4'd14, 1, 0,  1, 1, 0, 4'd1, 1);
    addVec("rst_midstream",   1, 0, 1, 4'd10, 1, 0,  1, 0, 1, 4'd0, 0);
    addVec("rst_after",       0, 0, 0, 4'd0, 0, 1,   1, 0, 1, 4'd0, 0);
    addVec("rf_push3",        0, 0, 1, 4'd3, 1, 0,   1, 1, 1, 4'd3, 1);
    addVec("rst_over_flush",  1, 1, 1, 4'd7, 1, 0,   1, 0, 1, 4'd0, 0);
    addVec("x_idle",          0, 0, 0, 4'bxxxx, 1, 0, 1, 0, 1, 4'd0, 0);
    addVec("push_after_x",    0, 0, 1, 4'd11, 0, 0,  1, 1, 1, 4'd11, 0);
  endtask

  // Run every directed vector: drive, clock, sample #1 after the edge
  task automatic runTable();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].data, vecs[i].en, vecs[i].ordy);
      @(posedge clk);
      #1;
      checkOutput({vecs[i].name, ".out_valid"}, i, {7'd0, out_valid}, {7'd0, vecs[i].expOv});
      checkOutput({vecs[i].name, ".in_ready"}, i, {7'd0, in_ready}, {7'd0, vecs[i].expIr});
      if (vecs[i].chkData) begin
        checkOutput({vecs[i].name, ".o0"}, i, {4'd0, o0}, {4'd0, vecs[i].expO0});
        checkOutput({vecs[i].name, ".o0_enable"}, i, {7'd0, o0_enable}, {7'd0, vecs[i].expEn});
      end
    end
  endtask

  // Random soak against a plain FIFO model holding at most two entries
  task automatic runSoak(input int cycles);
    logic         rst;
    logic         fl;
    logic         iv;
    logic         ordy;
    logic [W-1:0] data;
    logic         en;
    logic         expIr;
    logic         expOv;
    entry_t       head;
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    model.delete();
    for (int c = 0; c < cycles; c++) begin
      expIr = (model.size() < 2);
      expOv = (model.size() != 0);
      checkOutput("soak.in_ready", c, {7'd0, in_ready}, {7'd0, expIr});
      checkOutput("soak.out_valid", c, {7'd0, out_valid}, {7'd0, expOv});
      if (expOv) begin
        head = model[0];
        checkOutput("soak.head", c, {3'd0, o0_enable, o0}, {3'd0, head});
      end
      rst  = ($urandom_range(0, 255) == 0);
      fl   = ($urandom_range(0, 31) == 0);
      iv   = ($urandom_range(0, 9) < 6);
      ordy = ($urandom_range(0, 9) < 6);
      data = W'($urandom);
      en   = 1'($urandom);
      applyStimulus(rst, fl, iv, data, en, ordy);
      if (rst || fl) begin
        model.delete();
      end else begin
        if (expOv && ordy) void'(model.pop_front());
        if (iv && expIr) model.push_back({en, data});
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    buildTable();
    runTable();
    runSoak(10000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
